i2c_target: RTL and testbench

- I2C target (slave) endpoint: the responder for the team's I2C controller block.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and acks it, receives write bytes, and serves read bytes from a byte-wide handshake interface.
- Never stretches SCL; drives SDA open-drain (low or Z only).

---
 rtl/i2c_target_if.sv | 22 ++
 rtl/i2c_target.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Byte-wide host handshake between the I2C target and its user logic.
interface i2c_target_if;
   logic [7:0] IDATA;
   logic       IDRDY;
   logic       TX_REQ;
   logic [7:0] ODATA;
   logic       ODRDY;
   logic       O_RW;
   logic       OSTART;
   logic       OSTOP;
   logic       BUSY;

   modport slave (
      input  IDATA, IDRDY,
      output TX_REQ, ODATA, ODRDY, O_RW, OSTART, OSTOP, BUSY
   );

   modport master (
      output IDATA, IDRDY,
      input  TX_REQ, ODATA, ODRDY, O_RW, OSTART, OSTOP, BUSY
   );
endinterface

// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, write receive and
// read-byte service over a byte handshake. Never stretches SCL; SDA is open-drain.
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR  = 7'h42,
   parameter logic       SYNC_RST_VAL = 1'b1
) (
   input  logic        CLK,
   input  logic        NRST,
   input  logic        I2C_SCL,
   inout  wire         I2C_SDA,
   i2c_target_if.slave host
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BYTE_W - 1);
   localparam logic [CNT_W-1:0]  ALL_BITS = CNT_W'(BYTE_W);
   localparam logic [BYTE_W-1:0] TX_IDLE  = BYTE_W'(8'hFF);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_MACK, IGNORE
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [BYTE_W-1:0]  shift_q;
   logic [BYTE_W-1:0]  tx_buf_q;
   logic [BYTE_W-1:0]  odata_q;
   logic               tx_valid_q;
   logic               tx_load_q;
   logic               sda_oe_q;
   logic               odrdy_pend_q;
   logic               odrdy_q;
   logic               o_rw_q;
   logic               ostart_q;
   logic               ostop_q;
   logic               busy_q;
   logic               tx_req_q;
   logic               scl_s1_q, scl_s2_q, scl_d_q;
   logic               sda_s1_q, sda_s2_q, sda_d_q;

   logic               scl_rise, scl_fall, start_det, stop_det, tx_bit;
   logic [BYTE_W-1:0]  rx_byte, tx_src;

   // Two-flop synchronizer plus one delay flop per line for edge detection.
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         scl_s1_q <= SYNC_RST_VAL;
         scl_s2_q <= SYNC_RST_VAL;
         scl_d_q  <= SYNC_RST_VAL;
         sda_s1_q <= SYNC_RST_VAL;
         sda_s2_q <= SYNC_RST_VAL;
         sda_d_q  <= SYNC_RST_VAL;
      end else begin
         scl_s1_q <= I2C_SCL;
         scl_s2_q <= scl_s1_q;
         scl_d_q  <= scl_s2_q;
         sda_s1_q <= I2C_SDA;
         sda_s2_q <= sda_s1_q;
         sda_d_q  <= sda_s2_q;
      end
   end

   assign scl_rise  = scl_s2_q & ~scl_d_q;
   assign scl_fall  = ~scl_s2_q & scl_d_q;
   assign start_det = scl_s2_q & sda_d_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & ~sda_d_q & sda_s2_q;
   assign rx_byte   = {shift_q[BYTE_W-2:0], sda_s2_q};
   // A strobe landing on the load fall is forwarded straight into the shifter.
   assign tx_src    = host.IDRDY ? host.IDATA : (tx_valid_q ? tx_buf_q : TX_IDLE);
   assign tx_bit    = shift_q[3'(LAST_BIT - bit_cnt_q)];

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_buf_q     <= TX_IDLE;
         tx_valid_q   <= 1'b0;
         tx_load_q    <= 1'b0;
         sda_oe_q     <= 1'b0;
         odata_q      <= '0;
         odrdy_pend_q <= 1'b0;
         odrdy_q      <= 1'b0;
         o_rw_q       <= 1'b0;
         ostart_q     <= 1'b0;
         ostop_q      <= 1'b0;
         busy_q       <= 1'b0;
         tx_req_q     <= 1'b0;
      end else begin
         ostart_q     <= 1'b0;
         ostop_q      <= 1'b0;
         tx_req_q     <= 1'b0;
         odrdy_pend_q <= 1'b0;
         odrdy_q      <= odrdy_pend_q;
         if (host.IDRDY) begin
            tx_buf_q   <= host.IDATA;
            tx_valid_q <= 1'b1;
         end

         if (stop_det) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            tx_load_q <= 1'b0;
            busy_q    <= 1'b0;
            ostop_q   <= busy_q;
         end else if (start_det) begin
            state_q   <= ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            tx_load_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE, IGNORE: ;
               ADDR: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_q <= '0;
                        if (rx_byte[BYTE_W-1:1] == TARGET_ADDR) begin
                           o_rw_q   <= rx_byte[0];
                           ostart_q <= 1'b1;
                           busy_q   <= 1'b1;
                           tx_req_q <= rx_byte[0];
                           state_q  <= ADDR_ACK;
                        end else begin
                           state_q  <= IGNORE;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
               // First fall pulls SDA low, second fall releases and moves on.
               ADDR_ACK, RX_ACK: begin
                  if (scl_fall) begin
                     if (bit_cnt_q == '0) begin
                        sda_oe_q  <= 1'b1;
                        bit_cnt_q <= CNT_W'(1);
                     end else begin
                        bit_cnt_q <= '0;
                        if (state_q == ADDR_ACK && o_rw_q) begin
                           state_q    <= TX_DATA;
                           shift_q    <= tx_src;
                           tx_valid_q <= 1'b0;
                           sda_oe_q   <= ~tx_src[BYTE_W-1];
                        end else begin
                           state_q  <= RX_DATA;
                           sda_oe_q <= 1'b0;
                        end
                     end
                  end
               end
               RX_DATA: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == LAST_BIT) begin
                        odata_q      <= rx_byte;
                        odrdy_pend_q <= 1'b1;
                        bit_cnt_q    <= '0;
                        state_q      <= RX_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
               // Counter tracks rises; each fall drives the bit selected by it.
               TX_DATA: begin
                  if (scl_fall) begin
                     if (tx_load_q) begin
                        tx_load_q  <= 1'b0;
                        shift_q    <= tx_src;
                        tx_valid_q <= 1'b0;
                        sda_oe_q   <= ~tx_src[BYTE_W-1];
                     end else if (bit_cnt_q == ALL_BITS) begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= TX_MACK;
                     end else begin
                        sda_oe_q <= ~tx_bit;
                     end
                  end else if (scl_rise && !tx_load_q) begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end
               TX_MACK: begin
                  if (scl_rise) begin
                     bit_cnt_q <= '0;
                     if (!sda_s2_q) begin
                        tx_req_q  <= 1'b1;
                        tx_load_q <= 1'b1;
                        state_q   <= TX_DATA;
                     end else begin
                        state_q   <= IGNORE;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign I2C_SDA     = sda_oe_q ? 1'b0 : 1'bz;
   assign host.TX_REQ = tx_req_q;
   assign host.ODATA  = odata_q;
   assign host.ODRDY  = odrdy_q;
   assign host.O_RW   = o_rw_q;
   assign host.OSTART = ostart_q;
   assign host.OSTOP  = ostop_q;
   assign host.BUSY   = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, IDRDY responder and
// queue scoreboard for O_RW at OSTART and ODATA at ODRDY.
module tb_i2c_target;
   localparam int Q = 8;

   logic CLK = 1'b0;
   logic NRST;
   logic scl;
   logic m_sda_low;
   wire  sda_bus;

   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_target_if ifc ();

   i2c_target #(.TARGET_ADDR(7'h42), .SYNC_RST_VAL(1'b1)) dut (
      .CLK     (CLK),
      .NRST    (NRST),
      .I2C_SCL (scl),
      .I2C_SDA (sda_bus),
      .host    (ifc)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int ostart_cnt = 0, ostop_cnt = 0, odrdy_cnt = 0, txreq_cnt = 0, dut_low_cnt = 0;
   logic       exp_rw [$];
   logic [7:0] exp_rx [$];
   logic [7:0] rd_data [$];
   logic       e_rw;
   logic [7:0] e_rx;

   // Output monitor and scoreboard, sampled 1 time unit after the falling edge.
   always @(negedge CLK) begin
      #1;
      if (NRST === 1'b1) begin
         if (ifc.OSTART === 1'b1) begin
            ostart_cnt++;
            n_tests++;
            if (exp_rw.size() == 0) begin
               n_fail++;
               $display("FAIL ostart_unexpected: got OSTART with O_RW=%b, none expected", ifc.O_RW);
            end else begin
               e_rw = exp_rw.pop_front();
               if (ifc.O_RW !== e_rw || ifc.BUSY !== 1'b1) begin
                  n_fail++;
                  $display("FAIL ostart_rw: O_RW=%b BUSY=%b, expected O_RW=%b BUSY=1", ifc.O_RW, ifc.BUSY, e_rw);
               end
            end
         end
         if (ifc.ODRDY === 1'b1) begin
            odrdy_cnt++;
            n_tests++;
            if (exp_rx.size() == 0) begin
               n_fail++;
               $display("FAIL odrdy_unexpected: got ODATA=%h, none expected", ifc.ODATA);
            end else begin
               e_rx = exp_rx.pop_front();
               if (ifc.ODATA !== e_rx) begin
                  n_fail++;
                  $display("FAIL odata: got %h, expected %h", ifc.ODATA, e_rx);
               end
            end
         end
         if (ifc.OSTOP === 1'b1) ostop_cnt++;
         if (ifc.TX_REQ === 1'b1) txreq_cnt++;
         if (sda_bus === 1'b0 && !m_sda_low) dut_low_cnt++;
      end
   end

   // Read-data responder: answers each TX_REQ with the next queued byte, if any.
   initial begin
      ifc.IDRDY = 1'b0;
      ifc.IDATA = 8'h00;
      forever begin
         @(negedge CLK);
         #1;
         if (ifc.TX_REQ === 1'b1 && rd_data.size() > 0) begin
            ifc.IDATA = rd_data.pop_front();
            ifc.IDRDY = 1'b1;
            @(negedge CLK);
            #1;
            ifc.IDRDY = 1'b0;
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      m_sda_low = 1'b1; wait_clk(Q);
      scl = 1'b0;       wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      m_sda_low = 1'b0; wait_clk(2*Q);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; wait_clk(Q);
      scl = 1'b1;     wait_clk(2*Q);
      scl = 1'b0;     wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; wait_clk(Q);
      scl = 1'b1;       wait_clk(Q);
      b = sda_bus;      wait_clk(Q);
      scl = 1'b0;       wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
   endtask

   task automatic test_reset();
      NRST = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
      wait_clk(5);
      n_tests++;
      if (ifc.ODATA !== 8'h00 || ifc.O_RW !== 1'b0 || ifc.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_regs: ODATA=%h O_RW=%b BUSY=%b, expected 00/0/0", ifc.ODATA, ifc.O_RW, ifc.BUSY);
      end
      n_tests++;
      if ({ifc.OSTART, ifc.OSTOP, ifc.ODRDY, ifc.TX_REQ} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_pulses: got %b, expected 0000", {ifc.OSTART, ifc.OSTOP, ifc.ODRDY, ifc.TX_REQ});
      end
      n_tests++;
      if (sda_bus !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_sda: got %b, expected 1", sda_bus);
      end
      NRST = 1'b1;
      wait_clk(4);
   endtask

   task automatic test_write();
      int s0, d0, p0;
      logic a;
      s0 = ostart_cnt; d0 = odrdy_cnt; p0 = ostop_cnt;
      exp_rw.push_back(1'b0);
      i2c_start();
      write_byte(8'h84);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b, expected 0", a); end
      n_tests++;
      if (ifc.BUSY !== 1'b1) begin n_fail++; $display("FAIL wr_busy_addr: got %b, expected 1", ifc.BUSY); end
      exp_rx.push_back(8'hA5);
      write_byte(8'hA5);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack: got %b, expected 0", a); end
      n_tests++;
      if (ifc.BUSY !== 1'b1 || ifc.ODATA !== 8'hA5) begin
         n_fail++;
         $display("FAIL wr_busy_data: BUSY=%b ODATA=%h, expected 1/a5", ifc.BUSY, ifc.ODATA);
      end
      i2c_stop();
      n_tests++;
      if (ostart_cnt - s0 != 1 || odrdy_cnt - d0 != 1 || ostop_cnt - p0 != 1) begin
         n_fail++;
         $display("FAIL wr_counts: ostart=%0d odrdy=%0d ostop=%0d, expected 1/1/1",
                  ostart_cnt - s0, odrdy_cnt - d0, ostop_cnt - p0);
      end
      n_tests++;
      if (ifc.BUSY !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b, expected 0", ifc.BUSY); end
   endtask

   task automatic test_wrong_addr();
      logic [7:0] bad [2];
      int s0, d0, p0, l0;
      logic a;
      bad[0] = 8'h86;
      bad[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         s0 = ostart_cnt; d0 = odrdy_cnt; p0 = ostop_cnt; l0 = dut_low_cnt;
         i2c_start();
         write_byte(bad[k]);
         read_bit(a);
         n_tests++;
         if (a !== 1'b1) begin n_fail++; $display("FAIL bad_addr_nack[%0d]: got %b, expected 1", k, a); end
         write_byte(8'h11);
         read_bit(a);
         n_tests++;
         if (a !== 1'b1) begin n_fail++; $display("FAIL bad_data_nack[%0d]: got %b, expected 1", k, a); end
         n_tests++;
         if (ifc.BUSY !== 1'b0) begin n_fail++; $display("FAIL bad_busy[%0d]: got %b, expected 0", k, ifc.BUSY); end
         i2c_stop();
         n_tests++;
         if (ostart_cnt != s0 || odrdy_cnt != d0 || ostop_cnt != p0 || dut_low_cnt != l0) begin
            n_fail++;
            $display("FAIL bad_quiet[%0d]: ostart=%0d odrdy=%0d ostop=%0d sda_low=%0d, expected all 0",
                     k, ostart_cnt - s0, odrdy_cnt - d0, ostop_cnt - p0, dut_low_cnt - l0);
         end
      end
   endtask

   task automatic test_read();
      int t0, p0;
      logic a;
      logic [7:0] d;
      t0 = txreq_cnt; p0 = ostop_cnt;
      rd_data.push_back(8'h3C);
      rd_data.push_back(8'hC3);
      exp_rw.push_back(1'b1);
      i2c_start();
      write_byte(8'h85);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b, expected 0", a); end
      read_byte(d);
      n_tests++;
      if (d !== 8'h3C) begin n_fail++; $display("FAIL rd_byte0: got %h, expected 3c", d); end
      write_bit(1'b0);
      read_byte(d);
      n_tests++;
      if (d !== 8'hC3) begin n_fail++; $display("FAIL rd_byte1: got %h, expected c3", d); end
      write_bit(1'b1);
      m_sda_low = 1'b0;
      wait_clk(Q);
      n_tests++;
      if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rd_release: got %b, expected 1", sda_bus); end
      n_tests++;
      if (txreq_cnt - t0 != 2) begin n_fail++; $display("FAIL rd_txreq: got %0d, expected 2", txreq_cnt - t0); end
      i2c_stop();
      n_tests++;
      if (ostop_cnt - p0 != 1 || ifc.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_stop: ostop=%0d BUSY=%b, expected 1/0", ostop_cnt - p0, ifc.BUSY);
      end
   endtask

   task automatic test_read_underrun();
      int t0, p0;
      logic a;
      logic [7:0] d;
      t0 = txreq_cnt; p0 = ostop_cnt;
      exp_rw.push_back(1'b1);
      i2c_start();
      write_byte(8'h85);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0) begin n_fail++; $display("FAIL ur_addr_ack: got %b, expected 0", a); end
      read_byte(d);
      n_tests++;
      if (d !== 8'hFF) begin n_fail++; $display("FAIL ur_byte: got %h, expected ff", d); end
      write_bit(1'b1);
      i2c_stop();
      n_tests++;
      if (txreq_cnt - t0 != 1 || ostop_cnt - p0 != 1) begin
         n_fail++;
         $display("FAIL ur_counts: txreq=%0d ostop=%0d, expected 1/1", txreq_cnt - t0, ostop_cnt - p0);
      end
   endtask

   task automatic test_back_to_back();
      int s0, p0;
      logic a;
      logic [7:0] d;
      s0 = ostart_cnt; p0 = ostop_cnt;
      exp_rw.push_back(1'b0);
      i2c_start();
      write_byte(8'h84);
      read_bit(a);
      exp_rx.push_back(8'h12);
      write_byte(8'h12);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0 || ifc.ODATA !== 8'h12) begin
         n_fail++;
         $display("FAIL rs_write: ack=%b ODATA=%h, expected 0/12", a, ifc.ODATA);
      end
      i2c_start();
      n_tests++;
      if (ifc.BUSY !== 1'b0 || ostop_cnt != p0) begin
         n_fail++;
         $display("FAIL rs_restart: BUSY=%b ostop=%0d, expected 0/0", ifc.BUSY, ostop_cnt - p0);
      end
      rd_data.push_back(8'h5A);
      exp_rw.push_back(1'b1);
      write_byte(8'h85);
      read_bit(a);
      read_byte(d);
      n_tests++;
      if (a !== 1'b0 || d !== 8'h5A) begin
         n_fail++;
         $display("FAIL rs_read: ack=%b data=%h, expected 0/5a", a, d);
      end
      write_bit(1'b1);
      n_tests++;
      if (ostart_cnt - s0 != 2 || ostop_cnt != p0) begin
         n_fail++;
         $display("FAIL rs_pre_stop: ostart=%0d ostop=%0d, expected 2/0", ostart_cnt - s0, ostop_cnt - p0);
      end
      i2c_stop();
      n_tests++;
      if (ostop_cnt - p0 != 1) begin n_fail++; $display("FAIL rs_stop: got %0d, expected 1", ostop_cnt - p0); end
   endtask

   task automatic test_reset_during_ack();
      int p0;
      logic a;
      exp_rw.push_back(1'b0);
      i2c_start();
      write_byte(8'h84);
      m_sda_low = 1'b0;
      wait_clk(Q/2 + 2);
      n_tests++;
      if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL rst_ack_driven: got %b, expected 0", sda_bus); end
      NRST = 1'b0;
      @(posedge CLK);
      #1;
      n_tests++;
      if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b, expected 1", sda_bus); end
      n_tests++;
      if (ifc.ODATA !== 8'h00 || ifc.O_RW !== 1'b0 || ifc.BUSY !== 1'b0 ||
          {ifc.OSTART, ifc.OSTOP, ifc.ODRDY, ifc.TX_REQ} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_outputs: ODATA=%h O_RW=%b BUSY=%b pulses=%b, expected 00/0/0/0000",
                  ifc.ODATA, ifc.O_RW, ifc.BUSY, {ifc.OSTART, ifc.OSTOP, ifc.ODRDY, ifc.TX_REQ});
      end
      wait_clk(2);
      scl = 1'b1;
      wait_clk(4);
      NRST = 1'b1;
      wait_clk(Q);
      p0 = ostop_cnt;
      exp_rw.push_back(1'b0);
      i2c_start();
      write_byte(8'h84);
      read_bit(a);
      n_tests++;
      if (a !== 1'b0) begin n_fail++; $display("FAIL post_rst_ack: got %b, expected 0", a); end
      exp_rx.push_back(8'h77);
      write_byte(8'h77);
      read_bit(a);
      i2c_stop();
      n_tests++;
      if (a !== 1'b0 || ostop_cnt - p0 != 1) begin
         n_fail++;
         $display("FAIL post_rst_txn: ack=%b ostop=%0d, expected 0/1", a, ostop_cnt - p0);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrong_addr();
      test_read();
      test_read_underrun();
      test_back_to_back();
      test_reset_during_ack();
      wait_clk(4);
      n_tests++;
      if (exp_rw.size() != 0 || exp_rx.size() != 0 || rd_data.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: rw=%0d rx=%0d rd=%0d left, expected 0/0/0",
                  exp_rw.size(), exp_rx.size(), rd_data.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
